// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// data-size codes and the grant-index width helper.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } arbiter_state_t;

  localparam logic [1:0] DATA_SIZE_BYTE = 2'd0;
  localparam logic [1:0] DATA_SIZE_HALF = 2'd1;
  localparam logic [1:0] DATA_SIZE_WORD = 2'd2;

  // A single requester still needs a one-bit grant index.
  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory arbiter.
// slave = arbiter view, master = the requesters plus the memory port.
interface memory_arbiter_if #(
  parameter int SIZE            = 32,
  parameter int REQUESTER_COUNT = 2
);

  // Handshake: a requester holds enable and its request fields stable until it
  // sees its one-cycle ready; memory_enable stays high with stable fields until
  // the memory answers with a one-cycle memory_ready carrying memory_data_in.
  logic [REQUESTER_COUNT-1:0] requester_enable;
  logic [REQUESTER_COUNT-1:0] requester_operation;
  logic [1:0]                 requester_data_size [0:REQUESTER_COUNT-1];
  logic [SIZE-1:0]            requester_address   [0:REQUESTER_COUNT-1];
  logic [SIZE-1:0]            requester_data_out  [0:REQUESTER_COUNT-1];
  logic [REQUESTER_COUNT-1:0] requester_ready;
  logic [SIZE-1:0]            requester_data_in;

  logic                       memory_enable;
  logic                       memory_operation;
  logic [1:0]                 memory_data_size;
  logic [SIZE-1:0]            memory_address;
  logic [SIZE-1:0]            memory_data_out;
  logic                       memory_ready;
  logic [SIZE-1:0]            memory_data_in;

  modport slave (
    input  requester_enable, requester_operation, requester_data_size,
           requester_address, requester_data_out,
    output requester_ready, requester_data_in,
    output memory_enable, memory_operation, memory_data_size,
           memory_address, memory_data_out,
    input  memory_ready, memory_data_in
  );

  modport master (
    output requester_enable, requester_operation, requester_data_size,
           requester_address, requester_data_out,
    input  requester_ready, requester_data_in,
    input  memory_enable, memory_operation, memory_data_size,
           memory_address, memory_data_out,
    output memory_ready, memory_data_in
  );

endinterface

// File: rtl/memory_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping from REQUESTER_COUNT-1 back to 0.
module round_robin_picker #(
  parameter int REQUESTER_COUNT = 2,
  parameter int INDEX_SIZE      = 1
) (
  input  logic [REQUESTER_COUNT-1:0] request_i,
  input  logic [INDEX_SIZE-1:0]      pointer_i,
  output logic                       found_o,
  output logic [INDEX_SIZE-1:0]      index_o
);

  int candidate;

  always_comb begin
    found_o   = 1'b0;
    index_o   = '0;
    candidate = 0;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      // The pointer is always below REQUESTER_COUNT, so one subtraction wraps.
      candidate = int'(pointer_i) + i;
      if (candidate >= REQUESTER_COUNT) candidate = candidate - REQUESTER_COUNT;
      if (!found_o && request_i[candidate]) begin
        found_o = 1'b1;
        index_o = INDEX_SIZE'(candidate);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one downstream memory port among REQUESTER_COUNT memory units.
// Define MEMORY_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int SIZE            = 32,
  parameter int REQUESTER_COUNT = 2,
  parameter int INDEX_SIZE      = index_width(REQUESTER_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_arbiter_if.slave       bus,
  output logic [INDEX_SIZE-1:0] grant_index,
  output arbiter_state_t        state_o
);

  arbiter_state_t        state_q, state_d;
  logic [INDEX_SIZE-1:0] grant_q, grant_d;
  logic                  aborted_q, aborted_d;
  logic [SIZE-1:0]       read_data_q, read_data_d;
  logic                  hold_operation_q, hold_operation_d;
  logic [1:0]            hold_size_q, hold_size_d;
  logic [SIZE-1:0]       hold_address_q, hold_address_d;
  logic [SIZE-1:0]       hold_data_q, hold_data_d;

  logic                  pick_found;
  logic [INDEX_SIZE-1:0] pick_index;
  logic [INDEX_SIZE-1:0] pick_pointer;

`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
  assign pick_pointer = '0;
`else
  logic [INDEX_SIZE-1:0] priority_pointer_q, priority_pointer_d;
  assign pick_pointer = priority_pointer_q;
`endif

  round_robin_picker #(
    .REQUESTER_COUNT (REQUESTER_COUNT),
    .INDEX_SIZE      (INDEX_SIZE)
  ) u_picker (
    .request_i (bus.requester_enable),
    .pointer_i (pick_pointer),
    .found_o   (pick_found),
    .index_o   (pick_index)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      grant_q          <= '0;
      aborted_q        <= 1'b0;
      read_data_q      <= '0;
      hold_operation_q <= 1'b0;
      hold_size_q      <= '0;
      hold_address_q   <= '0;
      hold_data_q      <= '0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      aborted_q        <= aborted_d;
      read_data_q      <= read_data_d;
      hold_operation_q <= hold_operation_d;
      hold_size_q      <= hold_size_d;
      hold_address_q   <= hold_address_d;
      hold_data_q      <= hold_data_d;
    end
  end

`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) priority_pointer_q <= '0;
    else       priority_pointer_q <= priority_pointer_d;
  end
`endif

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    aborted_d        = aborted_q;
    read_data_d      = read_data_q;
    hold_operation_d = hold_operation_q;
    hold_size_d      = hold_size_q;
    hold_address_d   = hold_address_q;
    hold_data_d      = hold_data_q;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
    priority_pointer_d = priority_pointer_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d          = pick_index;
          hold_operation_d = bus.requester_operation[pick_index];
          hold_size_d      = bus.requester_data_size[pick_index];
          hold_address_d   = bus.requester_address[pick_index];
          hold_data_d      = bus.requester_data_out[pick_index];
          aborted_d        = 1'b0;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        // A withdrawn request still completes downstream; only its ready is
        // suppressed.
        if (!bus.requester_enable[grant_q]) aborted_d = 1'b1;
        if (bus.memory_ready) begin
          read_data_d = bus.memory_data_in;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
        if (grant_q == INDEX_SIZE'(REQUESTER_COUNT - 1)) priority_pointer_d = '0;
        else priority_pointer_d = grant_q + INDEX_SIZE'(1);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [REQUESTER_COUNT-1:0] ready_vec;

  always_comb begin
    ready_vec = '0;
    if (state_q == RESPOND && !aborted_q) ready_vec[grant_q] = 1'b1;
  end

  assign bus.requester_ready   = ready_vec;
  assign bus.requester_data_in = read_data_q;
  assign bus.memory_enable     = (state_q == ISSUE);
  assign bus.memory_operation  = hold_operation_q;
  assign bus.memory_data_size  = hold_size_q;
  assign bus.memory_address    = hold_address_q;
  assign bus.memory_data_out   = hold_data_q;
  assign grant_index           = grant_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter (two requesters); honours
// MEMORY_ARBITER_FIXED_PRIORITY_EN when the build defines it.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int SIZE = 32;
  localparam int N    = 2;
  localparam int IW   = 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [IW-1:0]  grant_index;
  arbiter_state_t state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  memory_arbiter_if #(.SIZE(SIZE), .REQUESTER_COUNT(N)) bus ();

  memory_arbiter #(.SIZE(SIZE), .REQUESTER_COUNT(N), .INDEX_SIZE(IW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .grant_index (grant_index),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  // ---------------- clock/reset and driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.requester_enable    = '0;
    bus.requester_operation = '0;
    for (int i = 0; i < N; i++) begin
      bus.requester_data_size[i] = DATA_SIZE_WORD;
      bus.requester_address[i]   = '0;
      bus.requester_data_out[i]  = '0;
    end
    bus.memory_ready   = 1'b0;
    bus.memory_data_in = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tests_run++; if (state_o !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", state_o, IDLE); end
    tests_run++; if (bus.memory_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_enable: got %b expected 0", bus.memory_enable); end
    tests_run++; if (bus.requester_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b expected 00", bus.requester_ready); end
    tests_run++; if (bus.requester_data_in !== 32'h0) begin tests_failed++; $display("FAIL reset_data_in: got %h expected 0", bus.requester_data_in); end
    tests_run++; if (grant_index !== 1'b0) begin tests_failed++; $display("FAIL reset_grant: got %0d expected 0", grant_index); end
    tests_run++; if ({bus.memory_operation, bus.memory_data_size, bus.memory_address, bus.memory_data_out} !== 67'h0) begin
      tests_failed++; $display("FAIL reset_mem_fields: got op=%b size=%0d addr=%h data=%h expected all 0",
        bus.memory_operation, bus.memory_data_size, bus.memory_address, bus.memory_data_out);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    apply_reset();
    bus.requester_enable       = 2'b01;
    bus.requester_data_size[0] = DATA_SIZE_WORD;
    bus.requester_address[0]   = 32'h100;
    tests_run++; if (state_o !== IDLE) begin tests_failed++; $display("FAIL load_c0_state: got %0d expected %0d", state_o, IDLE); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests_run++; if (bus.memory_enable !== 1'b1) begin tests_failed++; $display("FAIL load_c%0d_enable: got %b expected 1", c, bus.memory_enable); end
      tests_run++; if (bus.memory_address !== 32'h100) begin tests_failed++; $display("FAIL load_c%0d_addr: got %h expected 100", c, bus.memory_address); end
      tests_run++; if (bus.requester_ready !== 2'b00) begin tests_failed++; $display("FAIL load_c%0d_ready: got %b expected 00", c, bus.requester_ready); end
    end
    bus.memory_ready   = 1'b1;
    bus.memory_data_in = 32'hDEADBEEF;
    tick();
    bus.memory_ready   = 1'b0;
    bus.memory_data_in = 32'h0;
    tests_run++; if (bus.requester_ready !== 2'b01) begin tests_failed++; $display("FAIL load_c4_ready: got %b expected 01", bus.requester_ready); end
    tests_run++; if (bus.requester_data_in !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_c4_data: got %h expected deadbeef", bus.requester_data_in); end
    bus.requester_enable = 2'b00;
    tick();
    tests_run++; if (state_o !== IDLE) begin tests_failed++; $display("FAIL load_c5_state: got %0d expected %0d", state_o, IDLE); end
    tests_run++; if (bus.requester_ready !== 2'b00) begin tests_failed++; $display("FAIL load_c5_ready: got %b expected 00", bus.requester_ready); end
  endtask

  task automatic test_round_robin();
    logic [IW-1:0]   exp_g [4];
    logic [1:0]      exp_r;
    logic [SIZE-1:0] exp_a;
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    apply_reset();
    bus.requester_address[0] = 32'h10;
    bus.requester_address[1] = 32'h20;
    bus.requester_enable     = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_a = (exp_g[k] == 1'b1) ? 32'h20 : 32'h10;
      tests_run++; if (grant_index !== exp_g[k]) begin tests_failed++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, grant_index, exp_g[k]); end
      tests_run++; if (bus.memory_address !== exp_a) begin tests_failed++; $display("FAIL rr_addr%0d: got %h expected %h", k, bus.memory_address, exp_a); end
      bus.memory_ready   = 1'b1;
      bus.memory_data_in = 32'(k);
      tick();
      bus.memory_ready = 1'b0;
      exp_r = 2'b01 << exp_g[k];
      tests_run++; if (bus.requester_ready !== exp_r) begin tests_failed++; $display("FAIL rr_ready%0d: got %b expected %b", k, bus.requester_ready, exp_r); end
      tick();
    end
    bus.requester_enable = 2'b00;
    tick();
  endtask

  task automatic test_abort();
    apply_reset();
    bus.requester_address[1] = 32'h300;
    bus.requester_enable     = 2'b10;
    tick();
    tests_run++; if (grant_index !== 1'b1) begin tests_failed++; $display("FAIL abort_grant: got %0d expected 1", grant_index); end
    bus.requester_enable = 2'b00;
    tick();
    tests_run++; if (bus.memory_enable !== 1'b1) begin tests_failed++; $display("FAIL abort_still_issuing: got %b expected 1", bus.memory_enable); end
    bus.memory_ready   = 1'b1;
    bus.memory_data_in = 32'h55;
    tick();
    bus.memory_ready = 1'b0;
    tests_run++; if (state_o !== RESPOND) begin tests_failed++; $display("FAIL abort_respond_state: got %0d expected %0d", state_o, RESPOND); end
    tests_run++; if (bus.requester_ready !== 2'b00) begin tests_failed++; $display("FAIL abort_ready: got %b expected 00", bus.requester_ready); end
    tick();
    tests_run++; if (state_o !== IDLE) begin tests_failed++; $display("FAIL abort_idle: got %0d expected %0d", state_o, IDLE); end
    tests_run++; if (bus.requester_ready !== 2'b00) begin tests_failed++; $display("FAIL abort_ready_after: got %b expected 00", bus.requester_ready); end
  endtask

  task automatic test_address_hold();
    apply_reset();
    bus.requester_address[0] = 32'h40;
    bus.requester_enable     = 2'b01;
    tick();
    bus.requester_address[0] = 32'h80;
    tick();
    tests_run++; if (bus.memory_address !== 32'h40) begin tests_failed++; $display("FAIL hold_addr_a: got %h expected 40", bus.memory_address); end
    tick();
    tests_run++; if (bus.memory_address !== 32'h40) begin tests_failed++; $display("FAIL hold_addr_b: got %h expected 40", bus.memory_address); end
    bus.memory_ready = 1'b1;
    tick();
    bus.memory_ready = 1'b0;
    tests_run++; if (bus.requester_ready !== 2'b01) begin tests_failed++; $display("FAIL hold_ready: got %b expected 01", bus.requester_ready); end
    bus.requester_enable = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    logic [IW-1:0] exp_first;
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    apply_reset();
    bus.requester_enable = 2'b01;
    tick();
    bus.memory_ready = 1'b1;
    tick();
    bus.memory_ready     = 1'b0;
    bus.requester_enable = 2'b00;
    tick();
    bus.requester_enable = 2'b11;
    tick();
    tests_run++; if (grant_index !== exp_first) begin tests_failed++; $display("FAIL rst_pre_grant: got %0d expected %0d", grant_index, exp_first); end
    tests_run++; if (state_o !== ISSUE) begin tests_failed++; $display("FAIL rst_pre_state: got %0d expected %0d", state_o, ISSUE); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (bus.memory_enable !== 1'b0) begin tests_failed++; $display("FAIL rst_async_enable: got %b expected 0", bus.memory_enable); end
    tests_run++; if (state_o !== IDLE) begin tests_failed++; $display("FAIL rst_async_state: got %0d expected %0d", state_o, IDLE); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    tests_run++; if (grant_index !== 1'b0) begin tests_failed++; $display("FAIL rst_post_grant: got %0d expected 0", grant_index); end
    tests_run++; if (state_o !== ISSUE) begin tests_failed++; $display("FAIL rst_post_state: got %0d expected %0d", state_o, ISSUE); end
    bus.memory_ready = 1'b1;
    tick();
    bus.memory_ready     = 1'b0;
    bus.requester_enable = 2'b00;
    tests_run++; if (bus.requester_ready !== 2'b01) begin tests_failed++; $display("FAIL rst_post_ready: got %b expected 01", bus.requester_ready); end
    tick();
  endtask

  task automatic test_store_half();
    apply_reset();
    bus.requester_operation[1] = 1'b1;
    bus.requester_data_size[1] = DATA_SIZE_HALF;
    bus.requester_address[1]   = 32'h2002;
    bus.requester_data_out[1]  = 32'h1234;
    bus.requester_enable       = 2'b10;
    tick();
    bus.requester_operation[1] = 1'b0;
    bus.requester_data_size[1] = DATA_SIZE_WORD;
    bus.requester_data_out[1]  = 32'hFFFF;
    for (int c = 1; c <= 2; c++) begin
      tests_run++; if (bus.memory_operation !== 1'b1) begin tests_failed++; $display("FAIL store_op%0d: got %b expected 1", c, bus.memory_operation); end
      tests_run++; if (bus.memory_data_size !== 2'd1) begin tests_failed++; $display("FAIL store_size%0d: got %0d expected 1", c, bus.memory_data_size); end
      tests_run++; if (bus.memory_data_out !== 32'h1234) begin tests_failed++; $display("FAIL store_data%0d: got %h expected 1234", c, bus.memory_data_out); end
      tests_run++; if (bus.memory_address !== 32'h2002) begin tests_failed++; $display("FAIL store_addr%0d: got %h expected 2002", c, bus.memory_address); end
      if (c == 2) bus.memory_ready = 1'b1;
      tick();
    end
    bus.memory_ready = 1'b0;
    tests_run++; if (bus.requester_ready !== 2'b10) begin tests_failed++; $display("FAIL store_ready: got %b expected 10", bus.requester_ready); end
    bus.requester_enable = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_round_robin();
    test_abort();
    test_address_hold();
    test_reset_mid_issue();
    test_store_half();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
